mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Multi-cycle sequencer for RV32M multiply/divide, beside the single-cycle ALU in the execute stage.
//  Accepts one op via valid/ready, iterates one bit per cycle over shift/add/subtract state, returns one result via valid/ready.
//  The hazard unit stalls execute while busy=1.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count per op = WIDTH
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  flush       in   1      abort in-flight op (branch mispredict/trap)
//  req_valid   in   1      request present
//  req_ready   out  1      block can accept request
//  req_op      in   3      funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  req_a       in   WIDTH  rs1 value
//  req_b       in   WIDTH  rs2 value
//  req_rd      in   5      destination register tag
//  resp_valid  out  1      result present
//  resp_ready  in   1      consumer takes result
//  resp_data   out  WIDTH  result
//  resp_rd     out  5      tag of completed op
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, busy=0; req_ready=0 while rst=1, 1 on first cycle after.
//  req_ready = (state==IDLE) && !flush. Accept = req_valid && req_ready; op, operands, rd are captured.
//  FSM: IDLE -accept-> PREP -> CALC (WIDTH cycles, counter WIDTH-1..0) -> FIX -> DONE -resp_ready-> IDLE.
//  PREP: magnitudes per op signedness (MULH s*s, MULHSU s*u, MULHU u*u, DIV/REM signed, U variants unsigned).
//   Records neg flag: MUL*=sa^sb; quotient=sa^sb; remainder=sa.
//  PREP special cases go straight to DONE:
//   b==0: DIV/DIVU -> all-ones; REM/REMU -> a.
//   DIV a==0x80000000, b==all-ones -> 0x80000000; REM same -> 0.
//  CALC mul: shift-add into 2*WIDTH product. Div: restoring, WIDTH+1-bit remainder, one quotient bit/cycle.
//  FIX: two's-complement negate if neg flag; select low word (MUL, DIV*, REM*) or high word (MULH*).
//  Latency (accept edge to resp_valid=1): normal ops WIDTH+3 cycles (35); special cases 2 cycles.
//  DONE: resp_valid=1; resp_data/resp_rd held stable until resp_ready=1. IDLE the following cycle.
//   Next accept is possible then; no back-to-back within DONE.
//  resp_data/resp_rd keep their last value after the handshake; only resp_valid drops.
//  flush=1 in any state: next cycle IDLE, resp_valid=0, busy=0, result discarded. Flush beats resp_ready and req_valid.
//  req_valid while not IDLE: ignored, no capture.
//  rst mid-op: identical to reset values, op lost.
//  Operands are not re-sampled after accept; req_a/req_b may change freely.
// CONFIGURATION
//  MDU_MUL_EN defined: all eight ops implemented as above.
//  MDU_MUL_EN undefined: multiply datapath removed.
//   MUL* ops are still accepted and go PREP->DONE with resp_data=0, latency 2 cycles.
//   DIV/REM behaviour unchanged.
// TESTING
//  DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD, exactly 35 cycles after accept; REM same operands -> 0xFFFFFFFF.
//  DIVU a=0x64 b=0 -> 0xFFFFFFFF; REMU -> 0x64; both 2 cycles after accept, busy=1 in between.
//  DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; both at 2 cycles.
//  Multiply, MDU_MUL_EN set: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x0; MULHU -> 0xFFFFFFFE.
//   All at 35 cycles. Without MDU_MUL_EN: MUL -> 0 at 2 cycles.
//  Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_valid/resp_data/resp_rd stable, req_ready=0.
//   After handshake, req_ready=1 the next cycle.
//  flush on the 10th CALC cycle -> next cycle busy=0, resp_valid never asserts.
//   flush with req_valid in IDLE -> not accepted, busy stays 0.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Request/response handshake bundle between the execute stage and the mdu_seq sequencer.
// flush and busy also live here because they talk to the same pipeline control logic.
interface mdu_seq_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [4:0]       req_rd;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic [4:0]       resp_rd;
    logic             busy;

    modport master (
        output flush, req_valid, req_op, req_a, req_b, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, busy
    );
    modport slave (
        input  flush, req_valid, req_op, req_a, req_b, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, busy
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: one bit per cycle, shift-add multiply, restoring divide.
// Define MDU_MUL_EN to build the multiply datapath; otherwise MUL* ops complete immediately with 0.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_seq_if.slave  s
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             neg;
    logic [CW-1:0]    cnt;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [4:0]       resp_rd_q;

    logic             is_div, sgn_a, sgn_b, sa, sb, by_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] quot, rmd, fix_res;
`ifdef MDU_MUL_EN
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, prod_n;
`endif

    // Operand conditioning; lo holds raw rs1 until PREP replaces it with the magnitude.
    always_comb begin
        is_div  = op_q[2];
        sgn_a   = is_div ? !op_q[0] : (op_q[1:0] != 2'b11);
        sgn_b   = is_div ? !op_q[0] : !op_q[1];
        sa      = sgn_a && lo[WIDTH-1];
        sb      = sgn_b && b_q[WIDTH-1];
        a_mag   = sa ? -lo : lo;
        b_mag   = sb ? -b_q : b_q;
        by_zero = (b_q == '0);
        ovf     = !op_q[0] && (lo == MINV) && (b_q == '1);
    end

    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        quot    = neg ? -lo : lo;
        rmd     = neg ? -hi : hi;
        fix_res = op_q[1] ? rmd : quot;
`ifdef MDU_MUL_EN
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        prod    = {hi, lo};
        prod_n  = neg ? -prod : prod;
        if (!is_div)
            fix_res = (op_q[1:0] == 2'b00) ? prod_n[WIDTH-1:0] : prod_n[2*WIDTH-1:WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
        end else if (s.flush) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s.req_valid) begin
                    op_q  <= s.req_op;
                    lo    <= s.req_a;
                    b_q   <= s.req_b;
                    rd_q  <= s.req_rd;
                    state <= PREP;
                end
                PREP: begin
                    lo    <= a_mag;
                    b_q   <= b_mag;
                    hi    <= '0;
                    neg   <= (is_div && op_q[1]) ? sa : (sa ^ sb);
                    cnt   <= CW'(WIDTH - 1);
                    state <= CALC;
                    // Results that need no iteration bypass CALC/FIX entirely.
                    if (is_div && by_zero) begin
                        resp_data_q  <= op_q[1] ? lo : '1;
                        resp_rd_q    <= rd_q;
                        resp_valid_q <= 1'b1;
                        state        <= DONE;
                    end else if (is_div && ovf) begin
                        resp_data_q  <= op_q[1] ? '0 : MINV;
                        resp_rd_q    <= rd_q;
                        resp_valid_q <= 1'b1;
                        state        <= DONE;
                    end
`ifndef MDU_MUL_EN
                    else if (!is_div) begin
                        resp_data_q  <= '0;
                        resp_rd_q    <= rd_q;
                        resp_valid_q <= 1'b1;
                        state        <= DONE;
                    end
`endif
                end
                CALC: begin
                    if (is_div) begin
                        hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], !diff[WIDTH]};
                    end
`ifdef MDU_MUL_EN
                    else begin
                        hi <= sum[WIDTH:1];
                        lo <= {sum[0], lo[WIDTH-1:1]};
                    end
`endif
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    resp_data_q  <= fix_res;
                    resp_rd_q    <= rd_q;
                    resp_valid_q <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (s.resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s.req_ready  = (state == IDLE) && !s.flush && !rst;
    assign s.busy       = (state != IDLE);
    assign s.resp_valid = resp_valid_q;
    assign s.resp_data  = resp_data_q;
    assign s.resp_rd    = resp_rd_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: scoreboard queue of expected results, latency counted from the accept cycle (cycle 0).
// Builds against either configuration; multiply expectations follow MDU_MUL_EN.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) f();
    mdu_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .s(f));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef MDU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request; returns at the negedge of cycle 1 (one cycle after the accept cycle).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        f.req_valid = 1'b1;
        f.req_op    = op;
        f.req_a     = a;
        f.req_b     = b;
        f.req_rd    = rd;
        while (!f.req_ready && n < 100) begin @(negedge clk); n++; end
        chk("req_ready_before_accept", 64'(f.req_ready), 64'd1);
        @(negedge clk);
        f.req_valid = 1'b0;
        f.req_a     = $urandom;
        f.req_b     = $urandom;
    endtask

    task automatic await_resp(output int lat);
        lat = 1;
        while (!f.resp_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic check_resp(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"},  64'(lat), 64'(e.lat));
        chk({tag, "_data"}, 64'(f.resp_data), 64'(e.data));
        chk({tag, "_rd"},   64'(f.resp_rd), 64'(e.rd));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat_exp);
        int lat;
        sb.push_back('{exp, rd, lat_exp});
        issue(op, a, b, rd);
        chk({tag, "_busy"}, 64'(f.busy), 64'd1);
        await_resp(lat);
        check_resp(tag, lat);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 64'(f.resp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(f.req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  saw;
        rst          = 1'b1;
        f.flush      = 1'b0;
        f.req_valid  = 1'b0;
        f.req_op     = '0;
        f.req_a      = '0;
        f.req_b      = '0;
        f.req_rd     = '0;
        f.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  64'(f.req_ready),  64'd0);
        chk("rst_resp_valid", 64'(f.resp_valid), 64'd0);
        chk("rst_resp_data",  64'(f.resp_data),  64'd0);
        chk("rst_resp_rd",    64'(f.resp_rd),    64'd0);
        chk("rst_busy",       64'(f.busy),       64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(f.req_ready), 64'd1);

        // Special cases: two cycles from accept.
        run_op("divu_by0",  3'b101, 32'h64, 32'h0, 5'd1, 32'hFFFFFFFF, 2);
        run_op("remu_by0",  3'b111, 32'h64, 32'h0, 5'd2, 32'h00000064, 2);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h80000000, 2);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h00000000, 2);
        run_op("div_by0",   3'b100, 32'h12345678, 32'h0, 5'd5, 32'hFFFFFFFF, 2);

        // Iterating divides: 35 cycles.
        run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 35);
        run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 35);
        run_op("divu",      3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 35);
        run_op("remu",      3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 35);
        run_op("div_negb",  3'b100, 32'd7, 32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 35);
        run_op("rem_negb",  3'b110, 32'd7, 32'hFFFFFFFE, 5'd11, 32'd1, 35);
        run_op("divu_big",  3'b101, 32'hFFFFFFFF, 32'd1, 5'd12, 32'hFFFFFFFF, 35);

        // Multiplies: full datapath only when built with MDU_MUL_EN.
        run_op("mul",    3'b000, 32'd7, 32'hFFFFFFFD, 5'd13, MUL_ON ? 32'hFFFFFFEB : 32'h0, MUL_ON ? 35 : 2);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'h0, MUL_ON ? 35 : 2);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, MUL_ON ? 32'hFFFFFFFE : 32'h0, MUL_ON ? 35 : 2);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, MUL_ON ? 32'hFFFFFFFF : 32'h0, MUL_ON ? 35 : 2);

        // Backpressure in DONE.
        f.resp_ready = 1'b0;
        sb.push_back('{32'h80000000, 5'd17, 2});
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17);
        await_resp(lat);
        check_resp("bp", lat);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(f.resp_valid), 64'd1);
            chk("bp_data_hold",  64'(f.resp_data),  64'h80000000);
            chk("bp_rd_hold",    64'(f.resp_rd),    64'd17);
            chk("bp_req_ready",  64'(f.req_ready),  64'd0);
        end
        f.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop",  64'(f.resp_valid), 64'd0);
        chk("bp_ready_back",  64'(f.req_ready),  64'd1);
        chk("bp_data_keep",   64'(f.resp_data),  64'h80000000);
        chk("bp_rd_keep",     64'(f.resp_rd),    64'd17);

        // Flush on the 10th CALC cycle (CALC occupies cycles 2..33).
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd18);
        repeat (10) @(negedge clk);
        chk("flush_busy_before", 64'(f.busy), 64'd1);
        f.flush = 1'b1;
        @(negedge clk);
        f.flush = 1'b0;
        chk("flush_busy_after", 64'(f.busy), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (f.resp_valid) saw = 1'b1;
        end
        chk("flush_no_resp", 64'(saw), 64'd0);

        // Flush wins over req_valid in IDLE.
        @(negedge clk);
        f.flush     = 1'b1;
        f.req_valid = 1'b1;
        f.req_op    = 3'b101;
        #1;
        chk("flush_idle_ready", 64'(f.req_ready), 64'd0);
        @(negedge clk);
        f.flush     = 1'b0;
        f.req_valid = 1'b0;
        chk("flush_idle_busy", 64'(f.busy), 64'd0);

        // Operation still runs normally after a flush.
        run_op("after_flush", 3'b101, 32'd100, 32'd7, 5'd19, 32'd14, 35);

        // Reset in the middle of an op.
        issue(3'b101, 32'd1000, 32'd3, 5'd20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid",     64'(f.resp_valid), 64'd0);
        chk("midrst_busy",      64'(f.busy),       64'd0);
        chk("midrst_data",      64'(f.resp_data),  64'd0);
        chk("midrst_rd",        64'(f.resp_rd),    64'd0);
        chk("midrst_req_ready", 64'(f.req_ready),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", 64'(f.req_ready), 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
